branch_resolve_ctrl: RTL and testbench
======================================

Name: branch_resolve_ctrl

Overview:
- Sequences D-stage branch resolution around the shared 32-bit equality comparator: waits for forwarded operands, drives comparator inputs, evaluates the branch condition and issues a one-cycle registered PC redirect.
- Owns the D-stage branch stall. Sits between the D-stage register file/forwarding muxes, the comparator and the F-stage next-PC logic.

Parameters:
- DW, 32, operand and PC width.
- PERF_W, 32, performance counter width (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active-low
- br_valid  in  1  branch instruction present in D; held while stalled
- br_type  in  3  condition code, encodings from the shared package
- br_target  in  DW  branch target computed in D
- rs_val, rt_val  in  DW  forwarded operand values
- rs_ready, rt_ready  in  1  forwarded operand valid (no pending load/producer)
- d_hold  in  1  D stalled by another hazard source
- flush  in  1  exception/eret flush from a later stage
- cmp1, cmp2  out  DW  comparator operands
- cmp_eq  in  1  comparator result (cmp1 == cmp2)
- stall_d  out  1  branch-operand stall request to the hazard unit
- redirect_valid  out  1  redirect F to redirect_pc this cycle
- redirect_pc  out  DW  taken target
- busy  out  1  state != IDLE
- perf_taken, perf_not_taken, perf_stall  out  PERF_W  counters

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE. redirect_valid=0, redirect_pc=0, stall_d=0, busy=0, all counters=0.
- Condition encodings: BEQ, BNE, BLEZ, BGTZ, BLTZ, BGEZ.
- Operands: cmp1=rs_val. cmp2=rt_val for BEQ/BNE, else 0. Combinational; cmp1=cmp2=0 when br_valid=0.
- Decision:
  - BEQ=eq, BNE=!eq
  - BLEZ=rs[31]|eq, BGTZ=!rs[31]&!eq
  - BLTZ=rs[31], BGEZ=!rs[31]
- need_rt = BEQ|BNE. ops_ok = rs_ready & (rt_ready | !need_rt).
- stall_d = br_valid & !ops_ok & state!=RESOLVED (combinational).
- FSM, all transitions on clk:
  - IDLE: br_valid & !ops_ok -> WAIT. br_valid & ops_ok & !d_hold -> RESOLVED, decision registered. br_valid & ops_ok & d_hold -> stay IDLE, no resolution.
  - WAIT: ops_ok & !d_hold -> RESOLVED, decision registered. br_valid dropping -> IDLE.
  - RESOLVED: lasts exactly one cycle. redirect_valid = registered taken, redirect_pc = registered br_target; both are 0 when not taken. br_valid is ignored here (the delay-slot instruction is in D; a branch in a delay slot is illegal, so the bench asserts it never occurs). Next state: IDLE.
- Latency: operands ready in cycle N -> redirect_valid in cycle N+1. Each branch resolves exactly once.
- flush:
  - Highest priority. Next state=IDLE.
  - Registered redirect is cleared, so no redirect_valid in the next cycle.
  - If flush coincides with RESOLVED, redirect_valid is still forced 0 combinationally in that cycle.
- Reset mid-WAIT or mid-RESOLVED: same as flush, plus counters cleared.
- Undefined br_type: treated as not taken. Counts as not-taken.

Optional Feature:
- BRANCH_PERF_EN defined:
  - perf_taken / perf_not_taken increment once per resolution, on entry to RESOLVED.
  - Not counted if flush occurs in that same entry cycle.
  - perf_stall increments every cycle stall_d=1.
  - All counters wrap modulo 2^PERF_W.
- Undefined: counters absent and perf_* outputs tied to 0. Ports remain.

Decomposition:
- Shared package holds: br_type encodings (BEQ=0, BNE=1, BLEZ=2, BGTZ=3, BLTZ=4, BGEZ=5) and FSM state encodings (IDLE, WAIT, RESOLVED).
- One sub-module: branch_cond, a combinational block taking br_type, rs[31] and cmp_eq and producing taken and need_rt. The FSM and counters stay in the top.

Test Plan:
- BEQ, rs=rt=0x1234, both ready, d_hold=0 -> cmp2=0x1234; next cycle redirect_valid=1, redirect_pc=br_target=0x00003010 for one cycle. stall_d never 1.
- BNE, rs=5, rt_ready low for 3 cycles then rt=5 -> stall_d=1 for 3 cycles; then RESOLVED with redirect_valid=0. With BRANCH_PERF_EN: perf_stall=3, perf_not_taken=1.
- BLEZ rs=0 -> taken. BGTZ rs=0 -> not taken. BLTZ rs=0x80000000 -> taken. BGEZ rs=0x7FFFFFFF -> taken. In all four, cmp2=0.
- BEQ taken and flush=1 in the RESOLVED cycle -> redirect_valid=0; next state IDLE; perf_taken unchanged.
- BEQ ready with d_hold=1 for 2 cycles -> no transition, stall_d=0; resolves the cycle after d_hold drops; exactly one redirect.
- rst_n=0 while in WAIT -> next cycle all outputs 0, busy=0. Counters at 0xFFFFFFFF plus one increment wrap to 0.

Source files
------------

// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared encodings for D-stage branch resolution: condition codes and controller states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package branch_resolve_ctrl_pkg;

    // Branch condition codes as decoded in D; codes 6 and 7 are unused and resolve not-taken
    localparam logic [2:0] BR_BEQ  = 3'd0;
    localparam logic [2:0] BR_BNE  = 3'd1;
    localparam logic [2:0] BR_BLEZ = 3'd2;
    localparam logic [2:0] BR_BGTZ = 3'd3;
    localparam logic [2:0] BR_BLTZ = 3'd4;
    localparam logic [2:0] BR_BGEZ = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT     = 2'd1,
        ST_RESOLVED = 2'd2
    } br_state_t;

endpackage

// File: rtl/branch_resolve_ctrl_cond.sv
// Branch condition evaluation from the comparator result and the rs sign bit.
// Latency: purely combinational.
// Backpressure: none; need_rt tells the controller whether rt readiness matters.
module branch_cond
    import branch_resolve_ctrl_pkg::*;
(
    input  logic [2:0] br_type,
    input  logic       rs_sign,
    input  logic       cmp_eq,
    output logic       taken,
    output logic       need_rt
);

    // Decode the condition; the comparator sees rt for BEQ/BNE and zero otherwise
    always_comb begin
        taken   = 1'b0;
        need_rt = 1'b0;
        case (br_type)
            BR_BEQ: begin
                taken   = cmp_eq;
                need_rt = 1'b1;
            end
            BR_BNE: begin
                taken   = ~cmp_eq;
                need_rt = 1'b1;
            end
            BR_BLEZ: taken = rs_sign | cmp_eq;
            BR_BGTZ: taken = ~rs_sign & ~cmp_eq;
            BR_BLTZ: taken = rs_sign;
            BR_BGEZ: taken = ~rs_sign;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// D-stage branch resolution: steers the shared comparator, owns the branch-operand stall, issues PC redirect.
// Latency: operands ready (and D not held) in cycle N -> redirect_valid for exactly one cycle in N+1.
// Backpressure: stall_d holds D while operands are outstanding; d_hold defers resolution; flush kills it. Counters need BRANCH_PERF_EN.
module branch_resolve_ctrl
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int DW     = 32,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              br_valid,
    input  logic [2:0]        br_type,
    input  logic [DW-1:0]     br_target,
    input  logic [DW-1:0]     rs_val,
    input  logic [DW-1:0]     rt_val,
    input  logic              rs_ready,
    input  logic              rt_ready,
    input  logic              d_hold,
    input  logic              flush,
    output logic [DW-1:0]     cmp1,
    output logic [DW-1:0]     cmp2,
    input  logic              cmp_eq,
    output logic              stall_d,
    output logic              redirect_valid,
    output logic [DW-1:0]     redirect_pc,
    output logic              busy,
    output logic [PERF_W-1:0] perf_taken,
    output logic [PERF_W-1:0] perf_not_taken,
    output logic [PERF_W-1:0] perf_stall
);

    br_state_t     state;
    logic          taken;
    logic          need_rt;
    logic          ops_ok;
    logic          resolve;
    logic          taken_q;
    logic [DW-1:0] pc_q;

    branch_cond u_cond (
        .br_type (br_type),
        .rs_sign (rs_val[DW-1]),
        .cmp_eq  (cmp_eq),
        .taken   (taken),
        .need_rt (need_rt)
    );

    // Comparator steering, operand readiness, stall request and redirect gating
    always_comb begin
        cmp1 = '0;
        cmp2 = '0;
        if (br_valid) begin
            cmp1 = rs_val;
            if (need_rt) begin
                cmp2 = rt_val;
            end
        end
        ops_ok  = rs_ready & (rt_ready | ~need_rt);
        // The instruction in D during RESOLVED is the delay slot, never a branch
        stall_d = br_valid & ~ops_ok & (state != ST_RESOLVED);
        resolve = br_valid & ops_ok & ~d_hold & ~flush & (state != ST_RESOLVED);
        // A flush arriving in the redirect cycle must still suppress the redirect
        redirect_valid = (state == ST_RESOLVED) & taken_q & ~flush;
        redirect_pc    = redirect_valid ? pc_q : '0;
        busy           = (state != ST_IDLE);
    end

    // Controller FSM; the decision and target are captured on the edge into RESOLVED
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            taken_q <= 1'b0;
            pc_q    <= '0;
        end else if (flush) begin
            state   <= ST_IDLE;
            taken_q <= 1'b0;
            pc_q    <= '0;
        end else begin
            taken_q <= 1'b0;
            pc_q    <= '0;
            case (state)
                ST_IDLE: begin
                    if (br_valid && !ops_ok) begin
                        state <= ST_WAIT;
                    end else if (resolve) begin
                        state   <= ST_RESOLVED;
                        taken_q <= taken;
                        pc_q    <= taken ? br_target : '0;
                    end
                end
                ST_WAIT: begin
                    if (!br_valid) begin
                        state <= ST_IDLE;
                    end else if (resolve) begin
                        state   <= ST_RESOLVED;
                        taken_q <= taken;
                        pc_q    <= taken ? br_target : '0;
                    end
                end
                ST_RESOLVED: state <= ST_IDLE;
                default:     state <= ST_IDLE;
            endcase
        end
    end

`ifdef BRANCH_PERF_EN
    logic [PERF_W-1:0] taken_cnt;
    logic [PERF_W-1:0] not_taken_cnt;
    logic [PERF_W-1:0] stall_cnt;

    // Resolutions are tallied as the RESOLVED cycle completes, so one flushed in that cycle is not counted
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            taken_cnt     <= '0;
            not_taken_cnt <= '0;
            stall_cnt     <= '0;
        end else begin
            if (state == ST_RESOLVED && !flush) begin
                if (taken_q) begin
                    taken_cnt <= taken_cnt + PERF_W'(1);
                end else begin
                    not_taken_cnt <= not_taken_cnt + PERF_W'(1);
                end
            end
            if (stall_d) begin
                stall_cnt <= stall_cnt + PERF_W'(1);
            end
        end
    end

    assign perf_taken     = taken_cnt;
    assign perf_not_taken = not_taken_cnt;
    assign perf_stall     = stall_cnt;
`else
    assign perf_taken     = '0;
    assign perf_not_taken = '0;
    assign perf_stall     = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: directed scenarios followed by randomized branches.
// Expected values come from a cycle-level reference model of the branch rules kept here.
// Counters are expected only when BRANCH_PERF_EN is defined; narrow PERF_W exercises wrap.
module tb_branch_resolve_ctrl;

    localparam int DW = 32;
    localparam int PW = 8;
`ifdef BRANCH_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          br_valid;
    logic [2:0]    br_type;
    logic [DW-1:0] br_target;
    logic [DW-1:0] rs_val;
    logic [DW-1:0] rt_val;
    logic          rs_ready;
    logic          rt_ready;
    logic          d_hold;
    logic          flush;
    logic [DW-1:0] cmp1;
    logic [DW-1:0] cmp2;
    logic          cmp_eq;
    logic          stall_d;
    logic          redirect_valid;
    logic [DW-1:0] redirect_pc;
    logic          busy;
    logic [PW-1:0] perf_taken;
    logic [PW-1:0] perf_not_taken;
    logic [PW-1:0] perf_stall;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic          m_wait;
    logic          m_res;
    logic          m_taken;
    logic [DW-1:0] m_pc;
    logic [PW-1:0] m_cnt_t;
    logic [PW-1:0] m_cnt_nt;
    logic [PW-1:0] m_cnt_s;

    always #5 clk = ~clk;

    // Environment comparator
    assign cmp_eq = (cmp1 == cmp2);

    branch_resolve_ctrl #(.DW(DW), .PERF_W(PW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .br_valid       (br_valid),
        .br_type        (br_type),
        .br_target      (br_target),
        .rs_val         (rs_val),
        .rt_val         (rt_val),
        .rs_ready       (rs_ready),
        .rt_ready       (rt_ready),
        .d_hold         (d_hold),
        .flush          (flush),
        .cmp1           (cmp1),
        .cmp2           (cmp2),
        .cmp_eq         (cmp_eq),
        .stall_d        (stall_d),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .busy           (busy),
        .perf_taken     (perf_taken),
        .perf_not_taken (perf_not_taken),
        .perf_stall     (perf_stall)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Architectural branch outcome from signed arithmetic on the operands
    function automatic logic ref_taken(input logic [2:0] t, input logic [31:0] rs, input logic [31:0] rt);
        case (t)
            3'd0:    return rs == rt;
            3'd1:    return rs != rt;
            3'd2:    return $signed(rs) <= 0;
            3'd3:    return $signed(rs) > 0;
            3'd4:    return $signed(rs) < 0;
            3'd5:    return $signed(rs) >= 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic ref_ops_ok();
        logic uses_rt;
        uses_rt = (br_type == 3'd0) || (br_type == 3'd1);
        return rs_ready && (rt_ready || !uses_rt);
    endfunction

    function automatic logic [PW-1:0] perf_exp(input logic [PW-1:0] v);
        return PERF_ON ? v : '0;
    endfunction

    // Compare every DUT output against the model for the current cycle's inputs
    task automatic eval();
        logic uses_rt;
        logic stl;
        logic rv;
        #1;
        uses_rt = (br_type == 3'd0) || (br_type == 3'd1);
        stl     = br_valid && !ref_ops_ok() && !m_res;
        rv      = m_res && m_taken && !flush;
        check_val("cmp1", 64'(cmp1), 64'(br_valid ? rs_val : 32'd0));
        check_val("cmp2", 64'(cmp2), 64'((br_valid && uses_rt) ? rt_val : 32'd0));
        check_val("stall_d", 64'(stall_d), 64'(stl));
        check_val("redirect_valid", 64'(redirect_valid), 64'(rv));
        check_val("redirect_pc", 64'(redirect_pc), 64'(rv ? m_pc : 32'd0));
        check_val("busy", 64'(busy), 64'(m_wait || m_res));
        check_val("perf_taken", 64'(perf_taken), 64'(perf_exp(m_cnt_t)));
        check_val("perf_not_taken", 64'(perf_not_taken), 64'(perf_exp(m_cnt_nt)));
        check_val("perf_stall", 64'(perf_stall), 64'(perf_exp(m_cnt_s)));
        if (m_res && br_valid) $error("branch presented in a delay slot");
    endtask

    // Advance one clock and update the model from the inputs held across the edge
    task automatic tick();
        logic ok;
        logic stl;
        ok  = ref_ops_ok();
        stl = br_valid && !ok && !m_res;
        @(posedge clk);
        if (!rst_n) begin
            m_wait = 1'b0; m_res = 1'b0; m_taken = 1'b0; m_pc = '0;
            m_cnt_t = '0; m_cnt_nt = '0; m_cnt_s = '0;
        end else begin
            if (stl) m_cnt_s = m_cnt_s + 1'b1;
            if (flush) begin
                m_wait = 1'b0; m_res = 1'b0; m_taken = 1'b0;
            end else if (m_res) begin
                if (m_taken) m_cnt_t = m_cnt_t + 1'b1;
                else         m_cnt_nt = m_cnt_nt + 1'b1;
                m_res = 1'b0; m_taken = 1'b0;
            end else if (br_valid && ok && !d_hold) begin
                m_res   = 1'b1;
                m_wait  = 1'b0;
                m_taken = ref_taken(br_type, rs_val, rt_val);
                m_pc    = br_target;
            end else if (br_valid && !ok) begin
                m_wait = 1'b1;
            end else if (!br_valid) begin
                m_wait = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic set_br(input logic [2:0] t, input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] tg);
        br_type = t; rs_val = rs; rt_val = rt; br_target = tg;
    endtask

    task automatic drive(input logic v, input logic rsr, input logic rtr, input logic h, input logic f);
        br_valid = v; rs_ready = rsr; rt_ready = rtr; d_hold = h; flush = f;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0]  exp_tk [4];
        logic [31:0] rs_tk  [4];
        logic [31:0] v;
        exp_tk = '{1'b1, 1'b0, 1'b1, 1'b1};
        rs_tk  = '{32'h0, 32'h0, 32'h8000_0000, 32'h7FFF_FFFF};

        rst_n = 1'b0;
        set_br(3'd0, 32'd0, 32'd0, 32'd0);
        drive(0, 0, 0, 0, 0);
        tick();
        tick();
        rst_n = 1'b1;
        eval();
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_redirect_valid", 64'(redirect_valid), 64'd0);
        check_val("rst_redirect_pc", 64'(redirect_pc), 64'd0);
        tick();

        // BEQ taken with both operands ready
        set_br(3'd0, 32'h1234, 32'h1234, 32'h0000_3010);
        drive(1, 1, 1, 0, 0);
        eval();
        check_val("beq_cmp2", 64'(cmp2), 64'h1234);
        check_val("beq_no_stall", 64'(stall_d), 64'd0);
        tick();
        br_valid = 1'b0;
        eval();
        check_val("beq_redirect_valid", 64'(redirect_valid), 64'd1);
        check_val("beq_redirect_pc", 64'(redirect_pc), 64'h3010);
        tick();
        eval();
        check_val("beq_one_shot", 64'(redirect_valid), 64'd0);
        tick();

        // BNE waiting three cycles for rt, then not taken
        set_br(3'd1, 32'd5, 32'd5, 32'h0000_4000);
        drive(1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            eval();
            check_val("bne_stall", 64'(stall_d), 64'd1);
            tick();
        end
        rt_ready = 1'b1;
        eval();
        check_val("bne_ready_no_stall", 64'(stall_d), 64'd0);
        tick();
        br_valid = 1'b0;
        eval();
        check_val("bne_not_taken", 64'(redirect_valid), 64'd0);
        check_val("bne_busy", 64'(busy), 64'd1);
        tick();
        eval();
        check_val("bne_perf_stall", 64'(perf_stall), PERF_ON ? 64'd3 : 64'd0);
        check_val("bne_perf_not_taken", 64'(perf_not_taken), PERF_ON ? 64'd1 : 64'd0);
        tick();

        // Single-register conditions: rt readiness is irrelevant and cmp2 is zero
        for (int i = 0; i < 4; i++) begin
            set_br(3'(i + 2), rs_tk[i], 32'hDEAD_BEEF, 32'h0000_2000 + 32'(i * 4));
            drive(1, 1, 0, 0, 0);
            eval();
            check_val("single_cmp2", 64'(cmp2), 64'd0);
            tick();
            br_valid = 1'b0;
            eval();
            check_val("single_taken", 64'(redirect_valid), 64'(exp_tk[i]));
            tick();
        end

        // Flush in the redirect cycle suppresses the redirect and the count
        set_br(3'd0, 32'd7, 32'd7, 32'h0000_5000);
        drive(1, 1, 1, 0, 0);
        eval();
        tick();
        drive(0, 0, 0, 0, 1);
        eval();
        check_val("flush_redirect_valid", 64'(redirect_valid), 64'd0);
        tick();
        flush = 1'b0;
        eval();
        check_val("flush_idle", 64'(busy), 64'd0);
        check_val("flush_perf_taken", 64'(perf_taken), PERF_ON ? 64'd4 : 64'd0);
        tick();

        // d_hold defers resolution without a stall
        set_br(3'd0, 32'd9, 32'd9, 32'h0000_6000);
        drive(1, 1, 1, 1, 0);
        for (int i = 0; i < 2; i++) begin
            eval();
            check_val("hold_no_stall", 64'(stall_d), 64'd0);
            check_val("hold_idle", 64'(busy), 64'd0);
            tick();
        end
        d_hold = 1'b0;
        eval();
        tick();
        br_valid = 1'b0;
        eval();
        check_val("hold_redirect_pc", 64'(redirect_pc), 64'h6000);
        tick();
        eval();
        check_val("hold_single_redirect", 64'(redirect_valid), 64'd0);
        tick();

        // Reset while waiting
        set_br(3'd1, 32'd1, 32'd2, 32'h0000_7000);
        drive(1, 1, 0, 0, 0);
        eval();
        tick();
        eval();
        check_val("wait_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        br_valid = 1'b0;
        eval();
        tick();
        rst_n = 1'b1;
        eval();
        check_val("rstw_busy", 64'(busy), 64'd0);
        check_val("rstw_perf_stall", 64'(perf_stall), 64'd0);
        check_val("rstw_perf_taken", 64'(perf_taken), 64'd0);
        tick();

        // Stall counter wraps at 2^PW
        set_br(3'd0, 32'd3, 32'd3, 32'h0000_8000);
        drive(1, 1, 0, 0, 0);
        for (int i = 0; i < 255; i++) begin
            eval();
            tick();
        end
        eval();
        check_val("wrap_pre", 64'(perf_stall), PERF_ON ? 64'd255 : 64'd0);
        tick();
        rt_ready = 1'b1;
        eval();
        check_val("wrap_post", 64'(perf_stall), 64'd0);
        tick();
        br_valid = 1'b0;
        eval();
        tick();

        // Randomized branches
        for (int c = 0; c < 3000; c++) begin
            if (!br_valid && !m_res && $urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 4))
                    0:       v = 32'h0;
                    1:       v = 32'h8000_0000;
                    2:       v = 32'h7FFF_FFFF;
                    3:       v = 32'($urandom_range(0, 3));
                    default: v = $urandom;
                endcase
                set_br(3'($urandom_range(0, 7)), v, ($urandom_range(0, 1) == 1) ? v : $urandom,
                       $urandom & 32'hFFFF_FFFC);
                br_valid = 1'b1;
            end else if (br_valid && $urandom_range(0, 29) == 0) begin
                br_valid = 1'b0;
            end
            if (!br_valid) begin
                set_br(3'($urandom_range(0, 7)), $urandom, $urandom, $urandom);
            end
            rs_ready = ($urandom_range(0, 3) != 0);
            rt_ready = ($urandom_range(0, 3) != 0);
            d_hold   = ($urandom_range(0, 3) == 0);
            flush    = ($urandom_range(0, 19) == 0);
            eval();
            tick();
            if (m_res || flush) br_valid = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
